// File: rtl/gray_ptr_ctrl_pkg.sv
// Shared constants and Gray/binary helpers for the CDC FIFO pointer controllers.
// Helpers work on a zero-extended word, so any pointer width up to PTR_MAX_W is valid.
package gray_ptr_ctrl_pkg;

  localparam int MODE_WRITE = 0;
  localparam int MODE_READ  = 1;
  localparam int PTR_MAX_W  = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Zero upper bits decode to zero, so the result is exact for any narrower width.
  function automatic ptr_word_t gray2bin(input ptr_word_t gray);
    ptr_word_t bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_ptr_ctrl_if.sv
// Pointer-controller port bundle: advance request, remote Gray pointer in,
// local pointers, RAM address, full/empty flag and occupancy out.
interface gray_ptr_ctrl_if #(
  parameter int ADDR_WIDTH = 4
);

  logic                  incr;
  logic [ADDR_WIDTH:0]   remoteGray;
  logic [ADDR_WIDTH:0]   ptrGray;
  logic [ADDR_WIDTH:0]   ptrBin;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  flag;
  logic [ADDR_WIDTH:0]   level;

  modport master (
    output incr, remoteGray,
    input  ptrGray, ptrBin, addr, flag, level
  );

  modport slave (
    input  incr, remoteGray,
    output ptrGray, ptrBin, addr, flag, level
  );

endinterface

// File: rtl/gray_ptr_sync.sv
// Multi-flop synchroniser for the remote Gray pointer; latency STAGES edges.
// No backpressure: samples every edge. Flop names carry the cdc_sync_ prefix for CDC constraints.
module gray_ptr_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_d,
  output logic [WIDTH-1:0] sync_q
);

  logic [STAGES-1:0][WIDTH-1:0] cdc_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdc_sync_q <= '0;
    end else begin
      cdc_sync_q <= {cdc_sync_q[STAGES-2:0], async_d};
    end
  end

  assign sync_q = cdc_sync_q[STAGES-1];

endmodule

// File: rtl/gray_ptr_ctrl.sv
// Registered Gray FIFO pointer with synchronised remote pointer, full/empty flag and level.
// Local update same edge as incr; remote change visible SYNC_STAGES edges later; incr ignored while flag=1.
module gray_ptr_ctrl
  import gray_ptr_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int MODE        = MODE_WRITE,
  parameter int SYNC_STAGES = 2
) (
  input  logic           ACLK,
  input  logic           ARESETN,
  gray_ptr_ctrl_if.slave bus
);

  localparam int PW      = ADDR_WIDTH + 1;
  localparam bit IS_READ = (MODE == MODE_READ);

  // Full means the remote pointer is one lap behind: its top two Gray bits inverted.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("gray_ptr_ctrl: SYNC_STAGES must be 2..4");
  end

  logic [PW-1:0] ptr_bin_q;
  logic [PW-1:0] ptr_gray_q;
  logic          flag_q;
  logic [PW-1:0] level_q;

  logic          accept;
  logic [PW-1:0] bin_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] sync_gray;
  logic [PW-1:0] rem_bin;
  logic          flag_next;
  logic [PW-1:0] level_next;

  gray_ptr_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .async_d (bus.remoteGray),
    .sync_q  (sync_gray)
  );

  assign accept  = bus.incr & ~flag_q;
  assign rem_bin = PW'(gray2bin(ptr_word_t'(sync_gray)));

  always_comb begin
    bin_next   = ptr_bin_q;
    gray_next  = ptr_gray_q;
    flag_next  = 1'b0;
    level_next = '0;
    if (accept) begin
      bin_next  = ptr_bin_q + PW'(1);
      gray_next = PW'(bin2gray(ptr_word_t'(bin_next)));
    end
    // Flag and level use the post-increment pointer against the already-synchronised remote.
    if (IS_READ) begin
      flag_next  = (gray_next == sync_gray);
      level_next = rem_bin - bin_next;
    end else begin
      flag_next  = (gray_next == (sync_gray ^ FULL_MASK));
      level_next = bin_next - rem_bin;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ptr_bin_q  <= '0;
      ptr_gray_q <= '0;
      flag_q     <= IS_READ;
      level_q    <= '0;
    end else begin
      ptr_bin_q  <= bin_next;
      ptr_gray_q <= gray_next;
      flag_q     <= flag_next;
      level_q    <= level_next;
    end
  end

  assign bus.ptrBin  = ptr_bin_q;
  assign bus.ptrGray = ptr_gray_q;
  assign bus.addr    = ptr_bin_q[ADDR_WIDTH-1:0];
  assign bus.flag    = flag_q;
  assign bus.level   = level_q;

endmodule

// File: tb/tb_gray_ptr_ctrl.sv
// Directed bench for gray_ptr_ctrl: write side (2 and 4 sync stages) and read side, ADDR_WIDTH=2.
module tb_gray_ptr_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  gray_ptr_ctrl_if #(.ADDR_WIDTH(2)) wif  ();
  gray_ptr_ctrl_if #(.ADDR_WIDTH(2)) w4if ();
  gray_ptr_ctrl_if #(.ADDR_WIDTH(2)) rif  ();

  gray_ptr_ctrl #(.ADDR_WIDTH(2), .MODE(0), .SYNC_STAGES(2)) dut_w (
    .ACLK(clk), .ARESETN(rst_n), .bus(wif));
  gray_ptr_ctrl #(.ADDR_WIDTH(2), .MODE(0), .SYNC_STAGES(4)) dut_w4 (
    .ACLK(clk), .ARESETN(rst_n), .bus(w4if));
  gray_ptr_ctrl #(.ADDR_WIDTH(2), .MODE(1), .SYNC_STAGES(2)) dut_r (
    .ACLK(clk), .ARESETN(rst_n), .bus(rif));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    wif.incr = 1'b0;  wif.remoteGray = '0;
    w4if.incr = 1'b0; w4if.remoteGray = '0;
    rif.incr = 1'b0;  rif.remoteGray = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    #2 rst_n = 1'b0;
    #2;
    checks++; if (wif.ptrBin !== 3'b000) begin errors++; $display("FAIL reset_w_ptrBin got %b want 000", wif.ptrBin); end
    checks++; if (wif.ptrGray !== 3'b000) begin errors++; $display("FAIL reset_w_ptrGray got %b want 000", wif.ptrGray); end
    checks++; if (wif.addr !== 2'b00) begin errors++; $display("FAIL reset_w_addr got %b want 00", wif.addr); end
    checks++; if (wif.flag !== 1'b0) begin errors++; $display("FAIL reset_w_flag got %b want 0", wif.flag); end
    checks++; if (wif.level !== 3'd0) begin errors++; $display("FAIL reset_w_level got %0d want 0", wif.level); end
    checks++; if (rif.flag !== 1'b1) begin errors++; $display("FAIL reset_r_flag got %b want 1", rif.flag); end
    checks++; if (rif.level !== 3'd0) begin errors++; $display("FAIL reset_r_level got %0d want 0", rif.level); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (wif.ptrBin !== 3'b000 || wif.flag !== 1'b0) begin errors++; $display("FAIL reset_idle_w got bin %b flag %b want 000/0", wif.ptrBin, wif.flag); end
    checks++; if (rif.flag !== 1'b1) begin errors++; $display("FAIL reset_idle_r_flag got %b want 1", rif.flag); end
  endtask

  // Remote pointer trails the local one so the write side never fills during the walk.
  task automatic test_gray_sequence();
    logic [2:0] exp_gray [8];
    exp_gray = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      wif.incr = 1'b1;
      tick();
      checks++; if (wif.ptrGray !== exp_gray[k]) begin errors++; $display("FAIL seq_gray[%0d] got %b want %b", k, wif.ptrGray, exp_gray[k]); end
      checks++; if (wif.ptrBin !== 3'(k + 1)) begin errors++; $display("FAIL seq_bin[%0d] got %b want %b", k, wif.ptrBin, 3'(k + 1)); end
      checks++; if (wif.addr !== 2'(k + 1)) begin errors++; $display("FAIL seq_addr[%0d] got %b want %b", k, wif.addr, 2'(k + 1)); end
      checks++; if (wif.flag !== 1'b0) begin errors++; $display("FAIL seq_flag[%0d] got %b want 0", k, wif.flag); end
      wif.remoteGray = exp_gray[k];
    end
    wif.incr = 1'b0;
  endtask

  task automatic test_full_release();
    apply_reset();
    wif.incr = 1'b1;
    w4if.incr = 1'b1;
    repeat (3) tick();
    checks++; if (wif.level !== 3'd3 || wif.flag !== 1'b0) begin errors++; $display("FAIL full_pre got level %0d flag %b want 3/0", wif.level, wif.flag); end
    tick();
    checks++; if (wif.ptrBin !== 3'b100) begin errors++; $display("FAIL full_bin got %b want 100", wif.ptrBin); end
    checks++; if (wif.ptrGray !== 3'b110) begin errors++; $display("FAIL full_gray got %b want 110", wif.ptrGray); end
    checks++; if (wif.level !== 3'd4) begin errors++; $display("FAIL full_level got %0d want 4", wif.level); end
    checks++; if (wif.flag !== 1'b1) begin errors++; $display("FAIL full_flag got %b want 1", wif.flag); end
    checks++; if (w4if.flag !== 1'b1 || w4if.level !== 3'd4) begin errors++; $display("FAIL full_s4 got flag %b level %0d want 1/4", w4if.flag, w4if.level); end
    tick();
    checks++; if (wif.ptrBin !== 3'b100 || wif.ptrGray !== 3'b110 || wif.addr !== 2'b00) begin errors++; $display("FAIL full_ignore_ptr got bin %b gray %b addr %b want 100/110/00", wif.ptrBin, wif.ptrGray, wif.addr); end
    checks++; if (wif.level !== 3'd4 || wif.flag !== 1'b1) begin errors++; $display("FAIL full_ignore_flag got level %0d flag %b want 4/1", wif.level, wif.flag); end
    wif.incr = 1'b0;  wif.remoteGray = 3'b001;
    w4if.incr = 1'b0; w4if.remoteGray = 3'b001;
    repeat (2) tick();
    checks++; if (wif.flag !== 1'b1 || wif.level !== 3'd4) begin errors++; $display("FAIL release_early got flag %b level %0d want 1/4", wif.flag, wif.level); end
    tick();
    checks++; if (wif.flag !== 1'b0 || wif.level !== 3'd3) begin errors++; $display("FAIL release_s2 got flag %b level %0d want 0/3", wif.flag, wif.level); end
    tick();
    checks++; if (w4if.flag !== 1'b1 || w4if.level !== 3'd4) begin errors++; $display("FAIL release_s4_early got flag %b level %0d want 1/4", w4if.flag, w4if.level); end
    tick();
    checks++; if (w4if.flag !== 1'b0 || w4if.level !== 3'd3) begin errors++; $display("FAIL release_s4 got flag %b level %0d want 0/3", w4if.flag, w4if.level); end
  endtask

  task automatic test_empty();
    apply_reset();
    rif.incr = 1'b1;
    tick();
    checks++; if (rif.ptrBin !== 3'b000 || rif.flag !== 1'b1 || rif.level !== 3'd0) begin errors++; $display("FAIL empty_ignore got bin %b flag %b level %0d want 000/1/0", rif.ptrBin, rif.flag, rif.level); end
    rif.incr = 1'b0;
    rif.remoteGray = 3'b011;
    repeat (2) tick();
    checks++; if (rif.flag !== 1'b1) begin errors++; $display("FAIL empty_early got flag %b want 1", rif.flag); end
    tick();
    checks++; if (rif.flag !== 1'b0 || rif.level !== 3'd2) begin errors++; $display("FAIL empty_fill got flag %b level %0d want 0/2", rif.flag, rif.level); end
    rif.incr = 1'b1;
    tick();
    checks++; if (rif.ptrBin !== 3'b001 || rif.level !== 3'd1 || rif.flag !== 1'b0) begin errors++; $display("FAIL empty_pop1 got bin %b level %0d flag %b want 001/1/0", rif.ptrBin, rif.level, rif.flag); end
    tick();
    checks++; if (rif.ptrBin !== 3'b010 || rif.level !== 3'd0 || rif.flag !== 1'b1) begin errors++; $display("FAIL empty_pop2 got bin %b level %0d flag %b want 010/0/1", rif.ptrBin, rif.level, rif.flag); end
    tick();
    checks++; if (rif.ptrBin !== 3'b010 || rif.ptrGray !== 3'b011) begin errors++; $display("FAIL empty_hold got bin %b gray %b want 010/011", rif.ptrBin, rif.ptrGray); end
    rif.incr = 1'b0;
  endtask

  task automatic test_simultaneous();
    apply_reset();
    rif.remoteGray = 3'b001;
    repeat (3) tick();
    checks++; if (rif.flag !== 1'b0 || rif.level !== 3'd1) begin errors++; $display("FAIL simul_setup got flag %b level %0d want 0/1", rif.flag, rif.level); end
    rif.remoteGray = 3'b011;
    rif.incr = 1'b1;
    tick();
    rif.incr = 1'b0;
    checks++; if (rif.ptrBin !== 3'b001 || rif.level !== 3'd0 || rif.flag !== 1'b1) begin errors++; $display("FAIL simul_edge got bin %b level %0d flag %b want 001/0/1", rif.ptrBin, rif.level, rif.flag); end
    tick();
    checks++; if (rif.level !== 3'd0 || rif.flag !== 1'b1) begin errors++; $display("FAIL simul_wait got level %0d flag %b want 0/1", rif.level, rif.flag); end
    tick();
    checks++; if (rif.level !== 3'd1 || rif.flag !== 1'b0) begin errors++; $display("FAIL simul_sync got level %0d flag %b want 1/0", rif.level, rif.flag); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    wif.remoteGray = 3'b010;
    rif.remoteGray = 3'b101;
    repeat (3) tick();
    wif.incr = 1'b1;
    rif.incr = 1'b1;
    repeat (5) tick();
    checks++; if (wif.ptrBin !== 3'b101 || wif.level !== 3'd2 || wif.flag !== 1'b0) begin errors++; $display("FAIL mid_pre_w got bin %b level %0d flag %b want 101/2/0", wif.ptrBin, wif.level, wif.flag); end
    checks++; if (rif.ptrBin !== 3'b101 || rif.level !== 3'd1 || rif.flag !== 1'b0) begin errors++; $display("FAIL mid_pre_r got bin %b level %0d flag %b want 101/1/0", rif.ptrBin, rif.level, rif.flag); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (wif.ptrBin !== 3'b000 || wif.ptrGray !== 3'b000 || wif.addr !== 2'b00) begin errors++; $display("FAIL mid_async_w_ptr got bin %b gray %b addr %b want 000/000/00", wif.ptrBin, wif.ptrGray, wif.addr); end
    checks++; if (wif.flag !== 1'b0 || wif.level !== 3'd0) begin errors++; $display("FAIL mid_async_w_flag got flag %b level %0d want 0/0", wif.flag, wif.level); end
    checks++; if (rif.ptrBin !== 3'b000 || rif.flag !== 1'b1 || rif.level !== 3'd0) begin errors++; $display("FAIL mid_async_r got bin %b flag %b level %0d want 000/1/0", rif.ptrBin, rif.flag, rif.level); end
    repeat (2) tick();
    checks++; if (wif.ptrBin !== 3'b000 || wif.ptrGray !== 3'b000 || wif.level !== 3'd0) begin errors++; $display("FAIL mid_hold_w got bin %b gray %b level %0d want 000/000/0", wif.ptrBin, wif.ptrGray, wif.level); end
    checks++; if (rif.ptrBin !== 3'b000 || rif.flag !== 1'b1) begin errors++; $display("FAIL mid_hold_r got bin %b flag %b want 000/1", rif.ptrBin, rif.flag); end
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_gray_sequence();
    test_full_release();
    test_empty();
    test_simultaneous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
